// File: rtl/gadget_drop.sv
// Falling power-up gadgets: spawned where a brick breaks, moved once per frame,
// checked one slot per cycle against the paddle, and rendered for the VGA scan.
`ifndef PIXELX_BIT_CNT
`define PIXELX_BIT_CNT 10
`endif
`ifndef PIXELY_BIT_CNT
`define PIXELY_BIT_CNT 10
`endif

module gadget_drop #(
    parameter int SLOTS     = 4,
    parameter int FALL_STEP = 2,
    parameter int GADGET_W  = 16,
    parameter int GADGET_H  = 8,
    parameter int SCREEN_H  = 480
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_frame_tick,
    input  logic                       i_gen,
    input  logic [3:0]                 i_gen_type,
    input  logic [`PIXELX_BIT_CNT-1:0] i_gen_x,
    input  logic [`PIXELY_BIT_CNT-1:0] i_gen_y,
    input  logic [`PIXELX_BIT_CNT-1:0] i_paddle_x,
    input  logic [`PIXELY_BIT_CNT-1:0] i_paddle_y,
    input  logic [6:0]                 i_paddle_half,
    input  logic                       i_clear,
    input  logic [`PIXELX_BIT_CNT-1:0] DrawX,
    input  logic [`PIXELY_BIT_CNT-1:0] DrawY,
    output logic [3:0]                 o_is_gadget,
    output logic                       o_catch,
    output logic [3:0]                 o_catch_type,
    output logic                       o_overflow,
    output logic [2:0]                 o_active
);
    localparam int XW = `PIXELX_BIT_CNT;
    localparam int YW = 10;
    localparam int KW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int CW = 16;

    localparam logic [CW-1:0] HALF_W = CW'(GADGET_W / 2);
    localparam logic [CW-1:0] GW_C   = CW'(GADGET_W);
    localparam logic [CW-1:0] GH_C   = CW'(GADGET_H);
    localparam logic [YW-1:0] SH_Y   = YW'(SCREEN_H);
    localparam logic [YW-1:0] STEP_Y = YW'(FALL_STEP);
    localparam logic [XW-1:0] HALF_X = XW'(GADGET_W / 2);
    localparam logic [KW-1:0] LAST_K = KW'(SLOTS - 1);

    typedef enum logic [1:0] {IDLE, MOVE, CHECK} state_t;

    state_t state_q, state_d;
    logic [KW-1:0] k_q, k_d;

    logic [SLOTS-1:0]         valid_q, valid_d;
    logic [SLOTS-1:0][3:0]    type_q, type_d;
    logic [SLOTS-1:0][XW-1:0] x_q, x_d;
    logic [SLOTS-1:0][YW-1:0] y_q, y_d;

    logic          pend_v_q, pend_v_d;
    logic [3:0]    pend_type_q, pend_type_d;
    logic [XW-1:0] pend_x_q, pend_x_d;
    logic [YW-1:0] pend_y_q, pend_y_d;

    logic       catch_q, catch_d;
    logic [3:0] catch_type_q, catch_type_d;
    logic       ovf_q, ovf_d;
    logic [2:0] active_q, active_d;

    logic is_idle, is_move, is_check, last_k;
    logic spawn_ok;
    logic [XW-1:0] spawn_x;
    logic [YW-1:0] spawn_y;
    logic free_found;
    logic [KW-1:0] free_idx;
    logic [CW-1:0] cx, cy, px, py, dx;
    logic hit;

    // FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (i_frame_tick) state_d = MOVE;
            MOVE:    state_d = CHECK;
            CHECK:   if (k_q == LAST_K) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (i_clear) state_d = IDLE;
    end

    // FSM: decoded outputs
    always_comb begin
        is_idle  = (state_q == IDLE);
        is_move  = (state_q == MOVE);
        is_check = (state_q == CHECK);
        last_k   = (k_q == LAST_K);
    end

    assign spawn_ok = i_gen && (i_gen_type != 4'd0);
    assign spawn_x  = (i_gen_x < HALF_X) ? '0 : i_gen_x - HALF_X;
    assign spawn_y  = YW'(i_gen_y);

    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                free_found = 1'b1;
                free_idx   = KW'(i);
            end
        end
    end

    // Paddle test on slot k; widened so neither sum nor difference can wrap.
    always_comb begin
        cy  = CW'(y_q[k_q]);
        cx  = CW'(x_q[k_q]) + HALF_W;
        py  = CW'(i_paddle_y);
        px  = CW'(i_paddle_x);
        dx  = (cx >= px) ? cx - px : px - cx;
        hit = (cy + GH_C >= py) && (cy <= py) && (dx <= CW'(i_paddle_half) + HALF_W);
    end

    always_comb begin
        valid_d      = valid_q;
        type_d       = type_q;
        x_d          = x_q;
        y_d          = y_q;
        pend_v_d     = pend_v_q;
        pend_type_d  = pend_type_q;
        pend_x_d     = pend_x_q;
        pend_y_d     = pend_y_q;
        catch_d      = 1'b0;
        catch_type_d = 4'd0;
        ovf_d        = 1'b0;
        k_d          = k_q;
        active_d     = 3'd0;

        if (is_idle) begin
            k_d = '0;
            if (pend_v_q) begin
                // Commit cycle: the held spawn wins, any new spawn is lost.
                pend_v_d = 1'b0;
                if (free_found) begin
                    valid_d[free_idx] = 1'b1;
                    type_d[free_idx]  = pend_type_q;
                    x_d[free_idx]     = pend_x_q;
                    y_d[free_idx]     = pend_y_q;
                end else begin
                    ovf_d = 1'b1;
                end
                if (spawn_ok) ovf_d = 1'b1;
            end else if (spawn_ok) begin
                if (free_found) begin
                    valid_d[free_idx] = 1'b1;
                    type_d[free_idx]  = i_gen_type;
                    x_d[free_idx]     = spawn_x;
                    y_d[free_idx]     = spawn_y;
                end else begin
                    ovf_d = 1'b1;
                end
            end
        end else begin
            if (spawn_ok) begin
                if (pend_v_q) begin
                    ovf_d = 1'b1;
                end else begin
                    pend_v_d    = 1'b1;
                    pend_type_d = i_gen_type;
                    pend_x_d    = spawn_x;
                    pend_y_d    = spawn_y;
                end
            end
            if (is_move) begin
                k_d = '0;
                for (int i = 0; i < SLOTS; i++)
                    if (valid_q[i]) y_d[i] = y_q[i] + STEP_Y;
            end
            if (is_check) begin
                if (valid_q[k_q]) begin
                    if (hit) begin
                        valid_d[k_q] = 1'b0;
                        catch_d      = 1'b1;
                        catch_type_d = type_q[k_q];
                    end else if (y_q[k_q] >= SH_Y) begin
                        valid_d[k_q] = 1'b0;
                    end
                end
                k_d = last_k ? '0 : k_q + 1'b1;
            end
        end

        if (i_clear) begin
            valid_d      = '0;
            pend_v_d     = 1'b0;
            catch_d      = 1'b0;
            catch_type_d = 4'd0;
            ovf_d        = 1'b0;
            k_d          = '0;
        end

        for (int i = 0; i < SLOTS; i++)
            active_d = active_d + 3'(valid_d[i]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k_q          <= '0;
            valid_q      <= '0;
            type_q       <= '0;
            x_q          <= '0;
            y_q          <= '0;
            pend_v_q     <= 1'b0;
            pend_type_q  <= 4'd0;
            pend_x_q     <= '0;
            pend_y_q     <= '0;
            catch_q      <= 1'b0;
            catch_type_q <= 4'd0;
            ovf_q        <= 1'b0;
            active_q     <= 3'd0;
        end else begin
            k_q          <= k_d;
            valid_q      <= valid_d;
            type_q       <= type_d;
            x_q          <= x_d;
            y_q          <= y_d;
            pend_v_q     <= pend_v_d;
            pend_type_q  <= pend_type_d;
            pend_x_q     <= pend_x_d;
            pend_y_q     <= pend_y_d;
            catch_q      <= catch_d;
            catch_type_q <= catch_type_d;
            ovf_q        <= ovf_d;
            active_q     <= active_d;
        end
    end

    // Lowest-index slot wins where sprites overlap.
    always_comb begin
        o_is_gadget = 4'd0;
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (valid_q[i] &&
                (CW'(DrawX) >= CW'(x_q[i])) && (CW'(DrawX) < CW'(x_q[i]) + GW_C) &&
                (CW'(DrawY) >= CW'(y_q[i])) && (CW'(DrawY) < CW'(y_q[i]) + GH_C))
                o_is_gadget = type_q[i];
        end
    end

    assign o_catch      = catch_q;
    assign o_catch_type = catch_type_q;
    assign o_overflow   = ovf_q;
    assign o_active     = active_q;

endmodule

// File: tb/tb_gadget_drop.sv
// Self-checking bench for gadget_drop: directed scenarios plus randomized frames
// compared against a slot-list model of the falling gadgets.
module tb_gadget_drop;
    localparam int SLOTS = 4;
    localparam int FS    = 2;
    localparam int GW    = 16;
    localparam int GH    = 8;
    localparam int SH    = 480;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       gen = 1'b0;
    logic [3:0] gen_type = 4'd0;
    logic [9:0] gen_x = 10'd0, gen_y = 10'd0;
    logic [9:0] pad_x = 10'd0, pad_y = 10'd0;
    logic [6:0] pad_half = 7'd0;
    logic       clr = 1'b0;
    logic [9:0] draw_x = 10'd0, draw_y = 10'd0;
    logic [3:0] is_g;
    logic       catch_o;
    logic [3:0] catch_t;
    logic       ovf;
    logic [2:0] active;

    int checks = 0;
    int errors = 0;

    gadget_drop #(.SLOTS(SLOTS), .FALL_STEP(FS), .GADGET_W(GW), .GADGET_H(GH), .SCREEN_H(SH)) dut (
        .clk(clk), .rst(rst), .i_frame_tick(tick), .i_gen(gen), .i_gen_type(gen_type),
        .i_gen_x(gen_x), .i_gen_y(gen_y), .i_paddle_x(pad_x), .i_paddle_y(pad_y),
        .i_paddle_half(pad_half), .i_clear(clr), .DrawX(draw_x), .DrawY(draw_y),
        .o_is_gadget(is_g), .o_catch(catch_o), .o_catch_type(catch_t),
        .o_overflow(ovf), .o_active(active)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    bit mv[SLOTS];
    int mt[SLOTS], mx[SLOTS], my[SLOTS];
    int exp_catch[$];
    int got_type[$];
    int got_cyc[$];

    function automatic void m_clear();
        for (int i = 0; i < SLOTS; i++) mv[i] = 0;
    endfunction

    function automatic bit m_spawn(input int t, input int x, input int y);
        if (t == 0) return 0;
        for (int i = 0; i < SLOTS; i++)
            if (!mv[i]) begin
                mv[i] = 1; mt[i] = t; my[i] = y;
                mx[i] = (x < GW / 2) ? 0 : x - GW / 2;
                return 0;
            end
        return 1;
    endfunction

    function automatic void m_frame(input int px, input int py, input int half);
        exp_catch.delete();
        for (int i = 0; i < SLOTS; i++) if (mv[i]) my[i] += FS;
        for (int k = 0; k < SLOTS; k++)
            if (mv[k]) begin
                int d;
                d = mx[k] + GW / 2 - px;
                if (d < 0) d = -d;
                if (my[k] + GH >= py && my[k] <= py && d <= half + GW / 2) begin
                    mv[k] = 0;
                    exp_catch.push_back(mt[k]);
                end else if (my[k] >= SH) mv[k] = 0;
            end
    endfunction

    function automatic int m_active();
        int n = 0;
        for (int i = 0; i < SLOTS; i++) n += int'(mv[i]);
        return n;
    endfunction

    function automatic int m_lookup(input int dx, input int dy);
        for (int i = 0; i < SLOTS; i++)
            if (mv[i] && dx >= mx[i] && dx < mx[i] + GW && dy >= my[i] && dy < my[i] + GH)
                return mt[i];
        return 0;
    endfunction

    // ---------------- drivers ----------------
    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic drive_gen(input int t, input int x, input int y);
        gen = 1'b1; gen_type = 4'(t); gen_x = 10'(x); gen_y = 10'(y);
    endtask

    task automatic do_spawn(input int t, input int x, input int y, output bit exp_ovf);
        drive_gen(t, x, y);
        cyc();
        gen = 1'b0;
        exp_ovf = m_spawn(t, x, y);
    endtask

    task automatic do_clear();
        clr = 1'b1; cyc(); clr = 1'b0; m_clear();
    endtask

    task automatic set_draw(input int dx, input int dy);
        draw_x = 10'(dx); draw_y = 10'(dy); #1;
    endtask

    task automatic collect(input int n);
        got_type.delete(); got_cyc.delete();
        for (int c = 1; c <= n; c++) begin
            cyc();
            if (catch_o === 1'b1) begin
                got_type.push_back(int'(catch_t));
                got_cyc.push_back(c);
            end
        end
    endtask

    task automatic run_frame(input int px, input int py, input int half);
        pad_x = 10'(px); pad_y = 10'(py); pad_half = 7'(half);
        tick = 1'b1; cyc(); tick = 1'b0;
        m_frame(px, py, half);
        collect(SLOTS + 3);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (2) cyc();
        set_draw(0, 0);
        checks++; if (active !== 3'd0) begin errors++; $display("FAIL reset_active got %0d exp 0", active); end
        checks++; if (catch_o !== 1'b0) begin errors++; $display("FAIL reset_catch got %0b exp 0", catch_o); end
        checks++; if (catch_t !== 4'd0) begin errors++; $display("FAIL reset_catch_type got %0d exp 0", catch_t); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_overflow got %0b exp 0", ovf); end
        checks++; if (is_g !== 4'd0) begin errors++; $display("FAIL reset_is_gadget got %0d exp 0", is_g); end
        rst = 1'b0;
        m_clear();
        cyc();
    endtask

    task automatic test_spawn();
        bit eo;
        int pts[4][2];
        do_clear();
        do_spawn(3, 200, 100, eo);
        checks++; if (ovf !== eo) begin errors++; $display("FAIL spawn_ovf got %0b exp %0b", ovf, eo); end
        checks++; if (active !== 3'd1) begin errors++; $display("FAIL spawn_active got %0d exp 1", active); end
        pts = '{'{192, 100}, '{208, 100}, '{207, 107}, '{192, 108}};
        for (int i = 0; i < 4; i++) begin
            set_draw(pts[i][0], pts[i][1]);
            checks++;
            if (is_g !== 4'(m_lookup(pts[i][0], pts[i][1])))
                begin errors++; $display("FAIL spawn_lookup(%0d,%0d) got %0d exp %0d", pts[i][0], pts[i][1], is_g, m_lookup(pts[i][0], pts[i][1])); end
        end
        do_spawn(7, 5, 300, eo);
        set_draw(0, 300);
        checks++; if (is_g !== 4'd7) begin errors++; $display("FAIL spawn_saturate got %0d exp 7", is_g); end
        checks++; if (active !== 3'(m_active())) begin errors++; $display("FAIL spawn_active2 got %0d exp %0d", active, m_active()); end
    endtask

    task automatic test_catch();
        bit eo;
        do_clear();
        do_spawn(3, 200, 100, eo);
        run_frame(200, 106, 30);
        checks++; if (got_type.size() != 1) begin errors++; $display("FAIL catch_count got %0d exp 1", got_type.size()); end
        if (got_type.size() >= 1) begin
            checks++; if (got_type[0] != 3) begin errors++; $display("FAIL catch_type got %0d exp 3", got_type[0]); end
        end
        checks++; if (active !== 3'(m_active())) begin errors++; $display("FAIL catch_active got %0d exp %0d", active, m_active()); end
        checks++; if (catch_o !== 1'b0) begin errors++; $display("FAIL catch_idle got %0b exp 0", catch_o); end
    endtask

    task automatic test_miss();
        bit eo;
        do_clear();
        do_spawn(9, 200, 478, eo);
        run_frame(900, 100, 5);
        checks++; if (got_type.size() != 0) begin errors++; $display("FAIL miss_catch got %0d pulses exp 0", got_type.size()); end
        checks++; if (active !== 3'd0) begin errors++; $display("FAIL miss_active got %0d exp 0", active); end
    endtask

    task automatic test_overflow();
        bit eo;
        do_clear();
        for (int i = 1; i <= 5; i++) begin
            do_spawn(i, 40 * i + 20, 50, eo);
            checks++; if (ovf !== eo) begin errors++; $display("FAIL ovf_spawn%0d got %0b exp %0b", i, ovf, eo); end
        end
        checks++; if (active !== 3'd4) begin errors++; $display("FAIL ovf_active got %0d exp 4", active); end
        cyc();
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_width got %0b exp 0", ovf); end
        do_spawn(0, 300, 50, eo);
        checks++; if (ovf !== eo) begin errors++; $display("FAIL ovf_type0 got %0b exp %0b", ovf, eo); end
    endtask

    task automatic test_pending_double();
        bit eo;
        do_clear();
        do_spawn(2, 100, 200, eo);
        do_spawn(6, 600, 200, eo);
        do_spawn(11, 110, 204, eo);
        pad_x = 10'd110; pad_y = 10'd208; pad_half = 7'd20;
        tick = 1'b1; cyc(); tick = 1'b0;
        m_frame(110, 208, 20);
        drive_gen(5, 300, 50);
        cyc();
        gen = 1'b0;
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL pend_accept_ovf got %0b exp 0", ovf); end
        collect(SLOTS + 2);
        eo = m_spawn(5, 300, 50);
        checks++; if (got_type.size() != exp_catch.size()) begin errors++; $display("FAIL pend_catch_count got %0d exp %0d", got_type.size(), exp_catch.size()); end
        for (int i = 0; i < got_type.size() && i < exp_catch.size(); i++) begin
            checks++; if (got_type[i] != exp_catch[i]) begin errors++; $display("FAIL pend_catch_type%0d got %0d exp %0d", i, got_type[i], exp_catch[i]); end
        end
        if (got_cyc.size() == 2) begin
            checks++; if (got_cyc[1] - got_cyc[0] != 2) begin errors++; $display("FAIL pend_catch_gap got %0d exp 2", got_cyc[1] - got_cyc[0]); end
        end
        set_draw(292, 50);
        checks++; if (is_g !== 4'(m_lookup(292, 50))) begin errors++; $display("FAIL pend_land got %0d exp %0d", is_g, m_lookup(292, 50)); end
        set_draw(292, 52);
        checks++; if (is_g !== 4'(m_lookup(292, 52))) begin errors++; $display("FAIL pend_unmoved_y got %0d exp %0d", is_g, m_lookup(292, 52)); end
        checks++; if (active !== 3'(m_active())) begin errors++; $display("FAIL pend_active got %0d exp %0d", active, m_active()); end
    endtask

    task automatic test_pending_overflow();
        bit eo;
        do_clear();
        pad_x = 10'd0; pad_y = 10'd0; pad_half = 7'd0;
        tick = 1'b1; cyc(); tick = 1'b0;
        m_frame(0, 0, 0);
        drive_gen(8, 320, 60); cyc();
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL pov_first got %0b exp 0", ovf); end
        drive_gen(9, 400, 60); cyc(); gen = 1'b0;
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL pov_second got %0b exp 1", ovf); end
        cyc();
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL pov_width got %0b exp 0", ovf); end
        cyc(); cyc();
        drive_gen(10, 500, 60); cyc(); gen = 1'b0;
        eo = m_spawn(8, 320, 60);
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL pov_commit got %0b exp 1", ovf); end
        checks++; if (active !== 3'(m_active())) begin errors++; $display("FAIL pov_active got %0d exp %0d", active, m_active()); end
        set_draw(312, 60);
        checks++; if (is_g !== 4'(m_lookup(312, 60))) begin errors++; $display("FAIL pov_land got %0d exp %0d", is_g, m_lookup(312, 60)); end
        set_draw(492, 60);
        checks++; if (is_g !== 4'(m_lookup(492, 60))) begin errors++; $display("FAIL pov_dropped got %0d exp %0d", is_g, m_lookup(492, 60)); end
    endtask

    task automatic test_clear();
        bit eo;
        do_clear();
        do_spawn(1, 100, 100, eo);
        do_spawn(2, 200, 100, eo);
        do_spawn(3, 300, 100, eo);
        clr = 1'b1; drive_gen(4, 50, 50);
        cyc();
        clr = 1'b0; gen = 1'b0;
        m_clear();
        set_draw(42, 50);
        checks++; if (active !== 3'd0) begin errors++; $display("FAIL clear_active got %0d exp 0", active); end
        checks++; if (catch_o !== 1'b0) begin errors++; $display("FAIL clear_catch got %0b exp 0", catch_o); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL clear_ovf got %0b exp 0", ovf); end
        checks++; if (is_g !== 4'd0) begin errors++; $display("FAIL clear_spawn_discard got %0d exp 0", is_g); end
    endtask

    task automatic test_reset_mid_check();
        bit eo;
        do_clear();
        do_spawn(1, 800, 100, eo);
        do_spawn(2, 820, 120, eo);
        do_spawn(3, 840, 140, eo);
        do_spawn(12, 300, 300, eo);
        pad_x = 10'd300; pad_y = 10'd304; pad_half = 7'd10;
        draw_x = 10'd292; draw_y = 10'd302;
        tick = 1'b1; cyc(); tick = 1'b0;
        cyc(); cyc();
        #2 rst = 1'b1;
        #1;
        m_clear();
        checks++; if (active !== 3'd0) begin errors++; $display("FAIL rstmid_active got %0d exp 0", active); end
        checks++; if (catch_o !== 1'b0 || catch_t !== 4'd0) begin errors++; $display("FAIL rstmid_catch got %0b/%0d exp 0/0", catch_o, catch_t); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL rstmid_ovf got %0b exp 0", ovf); end
        checks++; if (is_g !== 4'd0) begin errors++; $display("FAIL rstmid_is_gadget got %0d exp 0", is_g); end
        cyc();
        rst = 1'b0;
        collect(8);
        checks++; if (got_type.size() != 0) begin errors++; $display("FAIL rstmid_no_pulse got %0d pulses exp 0", got_type.size()); end
        checks++; if (active !== 3'd0) begin errors++; $display("FAIL rstmid_active_after got %0d exp 0", active); end
    endtask

    task automatic test_random();
        bit eo;
        do_clear();
        for (int it = 0; it < 30; it++) begin
            int n, px, py, half, j, cnt;
            int vl[$];
            n = int'($urandom_range(0, 3));
            for (int s = 0; s < n; s++) begin
                do_spawn(int'($urandom_range(0, 15)), int'($urandom_range(0, 639)), int'($urandom_range(0, 479)), eo);
                checks++; if (ovf !== eo) begin errors++; $display("FAIL rnd_ovf it%0d got %0b exp %0b", it, ovf, eo); end
            end
            vl.delete();
            for (int i = 0; i < SLOTS; i++) if (mv[i]) vl.push_back(i);
            if (vl.size() > 0) begin
                j = vl[$urandom_range(0, vl.size() - 1)];
                px = mx[j] + GW / 2 + int'($urandom_range(0, 60)) - 30;
                py = my[j] + FS + int'($urandom_range(0, 14)) - 3;
            end else begin
                px = int'($urandom_range(0, 639));
                py = int'($urandom_range(0, 479));
            end
            if (px < 0) px = 0;
            if (py < 0) py = 0;
            if (px > 1023) px = 1023;
            if (py > 1023) py = 1023;
            half = int'($urandom_range(0, 40));
            run_frame(px, py, half);
            checks++; if (got_type.size() != exp_catch.size()) begin errors++; $display("FAIL rnd_catch_count it%0d got %0d exp %0d", it, got_type.size(), exp_catch.size()); end
            cnt = (got_type.size() < exp_catch.size()) ? got_type.size() : exp_catch.size();
            for (int i = 0; i < cnt; i++) begin
                checks++; if (got_type[i] != exp_catch[i]) begin errors++; $display("FAIL rnd_catch_type it%0d #%0d got %0d exp %0d", it, i, got_type[i], exp_catch[i]); end
            end
            checks++; if (active !== 3'(m_active())) begin errors++; $display("FAIL rnd_active it%0d got %0d exp %0d", it, active, m_active()); end
            for (int i = 0; i < SLOTS; i++)
                if (mv[i]) begin
                    int dx, dy;
                    dx = mx[i] + int'($urandom_range(0, GW));
                    dy = my[i] + int'($urandom_range(0, GH));
                    set_draw(dx, dy);
                    checks++; if (is_g !== 4'(m_lookup(dx, dy))) begin errors++; $display("FAIL rnd_lookup it%0d (%0d,%0d) got %0d exp %0d", it, dx, dy, is_g, m_lookup(dx, dy)); end
                end
        end
    endtask

    initial begin
        test_reset();
        test_spawn();
        test_catch();
        test_miss();
        test_overflow();
        test_pending_double();
        test_pending_overflow();
        test_clear();
        test_reset_mid_check();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout reached at %0t", $time);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/gadget_drop.md
GADGET_DROP -- requirements
Module: gadget_drop

Interface
REQ-001 SHALL have parameter SLOTS, default 4, the number of concurrently falling gadgets.
REQ-002 SHALL have parameter FALL_STEP, default 2, the pixels fallen per frame tick.
REQ-003 SHALL have parameters GADGET_W, default 16, and GADGET_H, default 8, giving the sprite box in pixels.
REQ-004 SHALL have parameter SCREEN_H, default 480, the visible height in pixels.
REQ-005 Ports, as name / direction / width / meaning:
- clk  in  1  sole clock; all state is rising-edge.
- rst  in  1  asynchronous, active-high reset.
- i_frame_tick  in  1  one-cycle pulse once per video frame.
- i_gen  in  1  spawn pulse, from brick o_br_gadget_gen.
- i_gen_type  in  4  gadget type, from brick o_gadget_type; 0 means none.
- i_gen_x  in  `PIXELX_BIT_CNT  ball X at spawn.
- i_gen_y  in  `PIXELY_BIT_CNT  ball Y at spawn.
- i_paddle_x  in  `PIXELX_BIT_CNT  paddle centre X.
- i_paddle_y  in  `PIXELY_BIT_CNT  paddle top Y.
- i_paddle_half  in  7  paddle half-width.
- i_clear  in  1  flush all gadgets; used on stage change and on death.
- DrawX  in  `PIXELX_BIT_CNT  VGA query X.
- DrawY  in  `PIXELY_BIT_CNT  VGA query Y.
- o_is_gadget  out  4  gadget type at (DrawX, DrawY); 0 means none.
- o_catch  out  1  one-cycle pulse per caught gadget.
- o_catch_type  out  4  type of the caught gadget; valid with o_catch.
- o_overflow  out  1  one-cycle pulse when a spawn is dropped.
- o_active  out  3  number of valid slots.

Function
REQ-006 SHALL hold per slot: valid, type[3:0], x (`PIXELX_BIT_CNT), and y (10 bits, so y+FALL_STEP never wraps).
REQ-007 Spawn in IDLE: with i_gen=1 and i_gen_type!=0, SHALL write the lowest-index free slot on the next edge.
- x SHALL be i_gen_x-GADGET_W/2, saturating at 0.
- y SHALL be i_gen_y.
REQ-008 A spawn with i_gen_type=0 SHALL be ignored, with no overflow.
REQ-009 A spawn with all slots valid SHALL be dropped, and o_overflow SHALL be 1 on the following cycle only.
REQ-010 FSM states SHALL be IDLE, MOVE and CHECK.
- IDLE->MOVE on i_frame_tick.
- MOVE (1 cycle): every valid slot y+=FALL_STEP; go to CHECK with index k=0.
- CHECK: process slot k in one cycle, k++; after k=SLOTS-1, go to IDLE.
- i_frame_tick outside IDLE SHALL be ignored.
REQ-011 CHECK on valid slot k: caught iff all three hold:
- y+GADGET_H >= i_paddle_y;
- y <= i_paddle_y;
- |x+GADGET_W/2 - i_paddle_x| <= i_paddle_half+GADGET_W/2, computed unsigned without wrap.
REQ-012 On catch SHALL clear valid[k], and SHALL register o_catch=1 and o_catch_type=type[k] on the next cycle; multiple catches in one frame SHALL produce separate pulses on consecutive CHECK cycles in ascending slot order.
REQ-013 CHECK, not caught, y >= SCREEN_H: SHALL clear valid[k] silently.
REQ-014 Spawn arriving in MOVE or CHECK SHALL be held in a one-entry pending register.
- Committed per REQ-007 on the cycle the FSM returns to IDLE.
- Not moved in the current frame.
- A second spawn while pending is full SHALL be dropped with o_overflow.
- A spawn in the commit cycle SHALL be dropped with o_overflow.
REQ-015 i_clear SHALL have highest priority: on the next edge all valid=0, pending cleared, FSM=IDLE, no o_catch or o_overflow that cycle; a simultaneous spawn is discarded.
REQ-016 o_is_gadget SHALL be combinational: the type of the lowest-index valid slot with x<=DrawX<x+GADGET_W and y<=DrawY<y+GADGET_H, else 0.
REQ-017 o_active SHALL be the registered popcount of valid.

Reset
REQ-018 On rst=1, asynchronously:
- all valid=0, pending empty, FSM=IDLE, k=0;
- o_catch=0, o_catch_type=0, o_overflow=0, o_active=0.
REQ-019 Reset mid-CHECK SHALL abandon the frame with no catch pulse after release.

Verification
REQ-020 Spawn: type=3, x=200, y=100 -> slot0 x=192, y=100; o_active=1; o_is_gadget=3 at (192,100); 0 at (208,100).
REQ-021 Catch: paddle x=200, y=106, half=30; one tick -> y=102, o_catch=1 and o_catch_type=3 for exactly 1 cycle; o_active=0.
REQ-022 Miss: gadget at y=478, paddle far away; tick -> y=480 removed, no o_catch, o_active=0.
REQ-023 Overflow: 5 spawns in IDLE with SLOTS=4 -> slots 0-3 filled; o_overflow=1 for one cycle after the 5th spawn.
REQ-024 Pending and double catch: slots 0 and 2 in catch range, spawn issued in the MOVE cycle -> two o_catch pulses two cycles apart (slots 0, 2); spawn then lands in slot0 with unmoved y.
REQ-025 Clear: i_clear together with i_gen, 3 slots valid -> next cycle o_active=0, no pulses; rst asserted mid-CHECK -> all outputs 0 immediately.
